gcode_command_dispatcher: RTL

- Clocked, buffered successor to the combinational G-code controller interface.
- Accepts decoded G-code commands from the command memory through a valid/ready handshake and queues them in a parametrised FIFO.
- Maintains modal machine state (units, absolute/relative, motion mode, tool flags) and resolves relative moves into saturated absolute targets.
- Issues moves and tool changes to the motion controller over separate valid/ready handshakes; sits between the G-code memory reader and the SCARA motion controller.

---
 rtl/gcode_command_dispatcher.sv | 359 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gcode_command_dispatcher.sv
// ---------------------------------------------------------------------------
// gcode_command_dispatcher
//
// This block sits between the G-code memory reader and the SCARA motion
// controller. It accepts decoded commands, buffers them in a small FIFO, and
// executes them one at a time. It tracks the modal machine state and turns
// each move command into an absolute, saturated target for the controller.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake from the memory reader
//   cmd_code            opcode (0=G00 1=G01 2=G20 3=G21 4=G90 5=G91
//                       6=M2 7=M6 8=M72, 9-15 illegal)
//   cmd_x, cmd_y        coordinate or delta (signed); cmd_x also carries
//                       the tool number for M6
//   move_valid/ready    move handshake to the motion controller
//   move_x, move_y      absolute target (signed)
//   move_linear         1 = G01 linear move, 0 = G00 rapid move
//   tool_valid/ready    tool-change handshake to the motion controller
//   tool_num            requested tool
//   state_reg           {tool_change, raise_tool, absolute, inches, linear}
//   program_done        M2 executed; the dispatcher is halted until reset
//   illegal_cmd         sticky flag, set when an illegal opcode executes
//   fifo_level          current command FIFO occupancy
// ---------------------------------------------------------------------------
module gcode_command_dispatcher #(
    parameter int COORD_W = 14,
    parameter int DEPTH   = 4,
    parameter int TOOL_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_code,
    input  logic [COORD_W-1:0]       cmd_x,
    input  logic [COORD_W-1:0]       cmd_y,
    output logic                     move_valid,
    input  logic                     move_ready,
    output logic [COORD_W-1:0]       move_x,
    output logic [COORD_W-1:0]       move_y,
    output logic                     move_linear,
    output logic                     tool_valid,
    input  logic                     tool_ready,
    output logic [TOOL_W-1:0]        tool_num,
    output logic [4:0]               state_reg,
    output logic                     program_done,
    output logic                     illegal_cmd,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 + 2 * COORD_W;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [3:0] OP_G00 = 4'd0;
    localparam logic [3:0] OP_G01 = 4'd1;
    localparam logic [3:0] OP_G20 = 4'd2;
    localparam logic [3:0] OP_G21 = 4'd3;
    localparam logic [3:0] OP_G90 = 4'd4;
    localparam logic [3:0] OP_G91 = 4'd5;
    localparam logic [3:0] OP_M2  = 4'd6;
    localparam logic [3:0] OP_M6  = 4'd7;
    localparam logic [3:0] OP_M72 = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_WAIT_MOVE = 3'd2,
        ST_WAIT_TOOL = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // Signed add at one extra bit, clamped to the representable range.
    function automatic logic [COORD_W-1:0] sat_add(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] sum;
        sum = {a[COORD_W-1], a} + {b[COORD_W-1], b};
        if (sum[COORD_W] != sum[COORD_W-1]) begin
            // Overflow: the extra bit holds the true sign.
            if (sum[COORD_W]) begin
                sat_add = {1'b1, {(COORD_W-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(COORD_W-1){1'b1}}};
            end
        end else begin
            sat_add = sum[COORD_W-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           push_s;
    logic           pop_s;
    logic [EW-1:0]  head_s;

    state_t state_r;
    state_t state_s;

    assign fifo_full_s  = (count_r == FULL_LVL);
    assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
    assign cmd_ready    = !fifo_full_s && (state_r != ST_HALT);
    assign push_s       = cmd_valid && cmd_ready;
    // Popping only happens from IDLE, so a pop never competes with execution.
    assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
    assign head_s       = mem_r[rd_ptr_r];

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_code, cmd_x, cmd_y};
        end
    end

    // FIFO pointers and occupancy counter; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Working register, modal state and output registers
    // ------------------------------------------------------------------
    logic [3:0]          work_code_r;
    logic [COORD_W-1:0]  work_x_r;
    logic [COORD_W-1:0]  work_y_r;

    logic                linear_r,     linear_s;
    logic                inches_r,     inches_s;
    logic                absolute_r,   absolute_s;
    logic                raise_r,      raise_s;
    logic                tchange_r,    tchange_s;
    logic [COORD_W-1:0]  pos_x_r,      pos_x_s;
    logic [COORD_W-1:0]  pos_y_r,      pos_y_s;
    logic                move_valid_r, move_valid_s;
    logic [COORD_W-1:0]  move_x_r,     move_x_s;
    logic [COORD_W-1:0]  move_y_r,     move_y_s;
    logic                move_lin_r,   move_lin_s;
    logic                tool_valid_r, tool_valid_s;
    logic [TOOL_W-1:0]   tool_num_r,   tool_num_s;
    logic                done_r,       done_s;
    logic                illegal_r,    illegal_s;

    // Working register captures the FIFO head on each pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_code_r <= 4'd0;
            work_x_r    <= {COORD_W{1'b0}};
            work_y_r    <= {COORD_W{1'b0}};
        end else if (pop_s) begin
            work_code_r <= head_s[EW-1 -: 4];
            work_x_r    <= head_s[2*COORD_W-1 -: COORD_W];
            work_y_r    <= head_s[COORD_W-1:0];
        end else begin
            work_code_r <= work_code_r;
            work_x_r    <= work_x_r;
            work_y_r    <= work_y_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value logic for the FSM and all datapath registers.
    always_comb begin
        state_s      = state_r;
        linear_s     = linear_r;
        inches_s     = inches_r;
        absolute_s   = absolute_r;
        raise_s      = raise_r;
        tchange_s    = tchange_r;
        pos_x_s      = pos_x_r;
        pos_y_s      = pos_y_r;
        move_valid_s = move_valid_r;
        move_x_s     = move_x_r;
        move_y_s     = move_y_r;
        move_lin_s   = move_lin_r;
        tool_valid_s = tool_valid_r;
        tool_num_s   = tool_num_r;
        done_s       = done_r;
        illegal_s    = illegal_r;

        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_EXEC: begin
                case (work_code_r)
                    OP_G20: begin
                        inches_s = 1'b1;
                        state_s  = ST_IDLE;
                    end
                    OP_G21: begin
                        inches_s = 1'b0;
                        state_s  = ST_IDLE;
                    end
                    OP_G90: begin
                        absolute_s = 1'b1;
                        state_s    = ST_IDLE;
                    end
                    OP_G91: begin
                        absolute_s = 1'b0;
                        state_s    = ST_IDLE;
                    end
                    OP_M72: begin
                        raise_s = 1'b1;
                        state_s = ST_IDLE;
                    end
                    OP_G00, OP_G01: begin
                        linear_s   = (work_code_r == OP_G01);
                        move_lin_s = (work_code_r == OP_G01);
                        raise_s    = 1'b0;
                        tchange_s  = 1'b0;
                        // The absolute flag seen here was set by an earlier
                        // command, so modal changes never act retroactively.
                        if (absolute_r) begin
                            move_x_s = work_x_r;
                            move_y_s = work_y_r;
                        end else begin
                            move_x_s = sat_add(pos_x_r, work_x_r);
                            move_y_s = sat_add(pos_y_r, work_y_r);
                        end
                        move_valid_s = 1'b1;
                        state_s      = ST_WAIT_MOVE;
                    end
                    OP_M6: begin
                        tchange_s    = 1'b1;
                        tool_num_s   = work_x_r[TOOL_W-1:0];
                        tool_valid_s = 1'b1;
                        state_s      = ST_WAIT_TOOL;
                    end
                    OP_M2: begin
                        done_s  = 1'b1;
                        state_s = ST_HALT;
                    end
                    default: begin
                        illegal_s = 1'b1;
                        state_s   = ST_IDLE;
                    end
                endcase
            end

            ST_WAIT_MOVE: begin
                if (move_valid_r && move_ready) begin
                    // Position only advances once the controller owns the move.
                    pos_x_s      = move_x_r;
                    pos_y_s      = move_y_r;
                    move_valid_s = 1'b0;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_MOVE;
                end
            end

            ST_WAIT_TOOL: begin
                if (tool_valid_r && tool_ready) begin
                    // tool_change stays set until the next G00/G01.
                    tool_valid_s = 1'b0;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_TOOL;
                end
            end

            ST_HALT: begin
                state_s = ST_HALT;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Modal bits, position and handshake output registers; reset is a safe start
    // with the tool raised and absolute addressing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            linear_r     <= 1'b0;
            inches_r     <= 1'b0;
            absolute_r   <= 1'b1;
            raise_r      <= 1'b1;
            tchange_r    <= 1'b0;
            pos_x_r      <= {COORD_W{1'b0}};
            pos_y_r      <= {COORD_W{1'b0}};
            move_valid_r <= 1'b0;
            move_x_r     <= {COORD_W{1'b0}};
            move_y_r     <= {COORD_W{1'b0}};
            move_lin_r   <= 1'b0;
            tool_valid_r <= 1'b0;
            tool_num_r   <= {TOOL_W{1'b0}};
            done_r       <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            linear_r     <= linear_s;
            inches_r     <= inches_s;
            absolute_r   <= absolute_s;
            raise_r      <= raise_s;
            tchange_r    <= tchange_s;
            pos_x_r      <= pos_x_s;
            pos_y_r      <= pos_y_s;
            move_valid_r <= move_valid_s;
            move_x_r     <= move_x_s;
            move_y_r     <= move_y_s;
            move_lin_r   <= move_lin_s;
            tool_valid_r <= tool_valid_s;
            tool_num_r   <= tool_num_s;
            done_r       <= done_s;
            illegal_r    <= illegal_s;
        end
    end

    assign move_valid   = move_valid_r;
    assign move_x       = move_x_r;
    assign move_y       = move_y_r;
    assign move_linear  = move_lin_r;
    assign tool_valid   = tool_valid_r;
    assign tool_num     = tool_num_r;
    assign state_reg    = {tchange_r, raise_r, absolute_r, inches_r, linear_r};
    assign program_done = done_r;
    assign illegal_cmd  = illegal_r;
    assign fifo_level   = count_r;

endmodule
